// File: rtl/jk_drv_pkg.sv
// Shared types and helpers for the JK excitation driver.
// Holds the controller state encoding, the inverted JK characteristic table
// and the wrapping up/down count rule used to pick the next bank state.
package jk_drv_pkg;

    // Controller states. The explicit encoding keeps the state register a
    // plain two-bit vector for downstream tools.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        FAULT = 2'd2
    } state_t;

    // Inverted JK characteristic: given present Q and the wanted next Q,
    // return {J,K}. Don't-care terms are resolved to 0, so a cell is only
    // ever set or cleared, never toggled.
    function automatic logic [1:0] jk_excite(input logic q, input logic q_next);
        logic [1:0] jk;
        case ({q, q_next})
            2'b01:   jk = 2'b10;
            2'b10:   jk = 2'b01;
            default: jk = 2'b00;
        endcase
        return jk;
    endfunction

    // Modulo-(max+1) step: up wraps max -> 0, down wraps 0 -> max.
    function automatic int next_count(input int cnt, input logic up, input int max);
        int nxt;
        if (up) begin
            nxt = (cnt >= max) ? 0 : cnt + 1;
        end else begin
            nxt = (cnt <= 0) ? max : cnt - 1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/jk_excitation_driver.sv
// Steps an external negedge-clocked JK flip-flop bank through a wrapping
// up/down count and checks the bank against the intended value.
// Latency: en at edge N, J/K valid N..N+1, check and step_done at N+1.
// Flow: at most one step per two cycles; en ignored in DRIVE/FAULT and
// while ff_rst is high.
// Ports: clk/rst (sync, active-low), en/up step request, clr_err fault
// exit, q_fb bank readback; j/k bank excitation, ff_rst bank reset,
// expected count, step_done pulse, sticky mismatch.
module jk_excitation_driver
    import jk_drv_pkg::*;
#(
    parameter int WIDTH     = 2,
    parameter int MAX_COUNT = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             clr_err,
    input  logic [WIDTH-1:0] q_fb,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    output logic             ff_rst,
    output logic [WIDTH-1:0] expected,
    output logic             step_done,
    output logic             mismatch
);

    state_t           state;
    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] step_tgt;
    logic [WIDTH-1:0] j_nxt;
    logic [WIDTH-1:0] k_nxt;
    logic             q_out_of_range;

    // Next count the bank should move to if a step is accepted now.
    assign step_tgt = WIDTH'(next_count(int'(expected), up, MAX_COUNT));

    // A bank value beyond the terminal count cannot be adopted as the
    // count on resync; the bank is reset instead.
    assign q_out_of_range = (int'(q_fb) > MAX_COUNT);

    // Excitation is derived from the live bank Q, not from expected, so the
    // step lands on target even if the bank disagrees with our bookkeeping.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_excite
        logic [1:0] jk_bit;
        assign jk_bit    = jk_excite(q_fb[gi], step_tgt[gi]);
        assign j_nxt[gi] = jk_bit[1];
        assign k_nxt[gi] = jk_bit[0];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            j         <= '0;
            k         <= '0;
            target    <= '0;
            expected  <= '0;
            step_done <= 1'b0;
            mismatch  <= 1'b0;
            ff_rst    <= 1'b1;
        end else begin
            // J/K are only non-zero for the single DRIVE cycle; every other
            // cycle the bank holds.
            j         <= '0;
            k         <= '0;
            step_done <= 1'b0;
            ff_rst    <= 1'b0;

            case (state)
                IDLE: begin
                    // ff_rst still high means the bank is held in reset for
                    // this cycle, so a step would be lost.
                    if (en && !ff_rst) begin
                        j      <= j_nxt;
                        k      <= k_nxt;
                        target <= step_tgt;
                        state  <= DRIVE;
                    end
                end

                DRIVE: begin
                    // The bank moved on the falling edge mid-cycle; q_fb is
                    // the post-step value here.
                    expected  <= target;
                    step_done <= 1'b1;
                    if (q_fb == target) begin
                        state <= IDLE;
                    end else begin
                        mismatch <= 1'b1;
                        state    <= FAULT;
                    end
                end

                FAULT: begin
                    // en is dropped here, including when it coincides with
                    // clr_err.
                    if (clr_err) begin
                        mismatch <= 1'b0;
                        state    <= IDLE;
                        if (q_out_of_range) begin
                            expected <= '0;
                            ff_rst   <= 1'b1;
                        end else begin
                            expected <= q_fb;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jk_excitation_driver.sv
// Bench for jk_excitation_driver: directed vector table, a hand sequence on
// a MAX_COUNT=2 build, and a randomized run against a count-level model.
// The JK bank load is modelled per cell on the falling edge.
module tb_jk_excitation_driver;

    localparam int W  = 2;
    localparam int MA = 3;
    localparam int MB = 2;

    logic         clk;
    // DUT A (MAX_COUNT=3)
    logic         rst_a, en_a, up_a, clr_a;
    logic [W-1:0] j_a, k_a, exp_a, bank_a;
    logic         ff_a, done_a, mis_a;
    logic         frc_a;
    logic [W-1:0] frc_val_a;
    // DUT B (MAX_COUNT=2)
    logic         rst_b, en_b, up_b, clr_b;
    logic [W-1:0] j_b, k_b, exp_b, bank_b;
    logic         ff_b, done_b, mis_b;
    logic         frc_b;
    logic [W-1:0] frc_val_b;

    int n_pass  = 0;
    int n_total = 0;
    int q_cap;

    jk_excitation_driver #(.WIDTH(W), .MAX_COUNT(MA)) u_dut_a (
        .clk(clk), .rst(rst_a), .en(en_a), .up(up_a), .clr_err(clr_a),
        .q_fb(bank_a), .j(j_a), .k(k_a), .ff_rst(ff_a), .expected(exp_a),
        .step_done(done_a), .mismatch(mis_a)
    );

    jk_excitation_driver #(.WIDTH(W), .MAX_COUNT(MB)) u_dut_b (
        .clk(clk), .rst(rst_b), .en(en_b), .up(up_b), .clr_err(clr_b),
        .q_fb(bank_b), .j(j_b), .k(k_b), .ff_rst(ff_b), .expected(exp_b),
        .step_done(done_b), .mismatch(mis_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // JK cells: falling-edge clocked, async active-high reset; the force
    // path overrides a cell on a chosen falling edge.
    for (genvar gi = 0; gi < W; gi++) begin : g_bank
        always @(negedge clk or posedge ff_a) begin
            if (ff_a)       bank_a[gi] <= 1'b0;
            else if (frc_a) bank_a[gi] <= frc_val_a[gi];
            else            bank_a[gi] <= (j_a[gi] & ~bank_a[gi]) | (~k_a[gi] & bank_a[gi]);
        end
        always @(negedge clk or posedge ff_b) begin
            if (ff_b)       bank_b[gi] <= 1'b0;
            else if (frc_b) bank_b[gi] <= frc_val_b[gi];
            else            bank_b[gi] <= (j_b[gi] & ~bank_b[gi]) | (~k_b[gi] & bank_b[gi]);
        end
    end

    task automatic chk(input string name, input int act, input int want);
        n_total++;
        if (act == want) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", name, act, want);
    endtask

    // One clock for DUT A: drive inputs, let the bank move on the falling
    // edge, capture what the DUT will see, then return just after the edge.
    task automatic cyc_a(input bit r, e, u, c, f, input int fv);
        rst_a = r; en_a = e; up_a = u; clr_a = c; frc_a = f; frc_val_a = W'(fv);
        @(negedge clk); #1;
        q_cap = int'(bank_a);
        frc_a = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic cyc_b(input bit r, e, u, c, f, input int fv);
        rst_b = r; en_b = e; up_b = u; clr_b = c; frc_b = f; frc_val_b = W'(fv);
        @(negedge clk); #1;
        frc_b = 1'b0;
        @(posedge clk); #1;
    endtask

    // Count-level reference model of DUT A.
    int m_exp, m_tgt, m_phase, m_j, m_k;
    bit m_err, m_ff, m_done;

    task automatic model_step(input bit r, e, u, c, input int q);
        bit ff_was;
        int t;
        ff_was = m_ff;
        m_done = 0; m_ff = 0; m_j = 0; m_k = 0;
        if (!r) begin
            m_exp = 0; m_tgt = 0; m_phase = 0; m_err = 0; m_ff = 1;
        end else begin
            case (m_phase)
                0: if (e && !ff_was) begin
                    t = (m_exp + (u ? 1 : MA)) % (MA + 1);
                    m_j = ~q & t & 3;      // bits that must be set
                    m_k = q & ~t & 3;      // bits that must be cleared
                    m_tgt = t;
                    m_phase = 1;
                end
                1: begin
                    m_exp = m_tgt;
                    m_done = 1;
                    if (q == m_tgt) m_phase = 0;
                    else begin m_err = 1; m_phase = 2; end
                end
                default: if (c) begin
                    m_err = 0;
                    m_phase = 0;
                    if (q > MA) begin m_exp = 0; m_ff = 1; end
                    else m_exp = q;
                end
            endcase
        end
    endtask

    typedef struct {
        int r, e, u, c, f, fv;
        int xj, xk, xe, xd, xm, xff, xq;
    } vec_t;

    vec_t tbl[31];

    initial begin
        rst_a = 0; en_a = 0; up_a = 0; clr_a = 0; frc_a = 0; frc_val_a = '0;
        rst_b = 0; en_b = 0; up_b = 0; clr_b = 0; frc_b = 0; frc_val_b = '0;
        bank_a = '0; bank_b = '0;

        //           r e u c f fv   j k e d m ff q
        tbl[0]  = '{0,0,0,0,0,0,  0,0,0,0,0,1,0};
        tbl[1]  = '{0,0,0,0,0,0,  0,0,0,0,0,1,0};
        tbl[2]  = '{1,1,1,0,0,0,  0,0,0,0,0,0,0};  // en ignored, ff_rst drops
        tbl[3]  = '{1,1,1,0,0,0,  1,0,0,0,0,0,0};  // 0->1
        tbl[4]  = '{1,1,1,0,0,0,  0,0,1,1,0,0,1};
        tbl[5]  = '{1,1,1,0,0,0,  2,1,1,0,0,0,1};  // 1->2
        tbl[6]  = '{1,1,1,0,0,0,  0,0,2,1,0,0,2};
        tbl[7]  = '{1,1,1,0,0,0,  1,0,2,0,0,0,2};  // 2->3
        tbl[8]  = '{1,1,1,0,0,0,  0,0,3,1,0,0,3};
        tbl[9]  = '{1,1,1,0,0,0,  0,3,3,0,0,0,3};  // 3->0 wrap
        tbl[10] = '{1,1,1,0,0,0,  0,0,0,1,0,0,0};
        tbl[11] = '{1,1,1,0,0,0,  1,0,0,0,0,0,0};
        tbl[12] = '{1,1,1,0,0,0,  0,0,1,1,0,0,1};
        tbl[13] = '{0,0,0,0,0,0,  0,0,0,0,0,1,0};  // reset clears bank
        tbl[14] = '{1,0,0,0,0,0,  0,0,0,0,0,0,0};
        tbl[15] = '{1,1,0,0,0,0,  3,0,0,0,0,0,0};  // down 0->3
        tbl[16] = '{1,1,0,0,0,0,  0,0,3,1,0,0,3};
        tbl[17] = '{1,1,0,0,0,0,  0,1,3,0,0,0,3};  // down 3->2
        tbl[18] = '{1,0,0,0,0,0,  0,0,2,1,0,0,2};
        tbl[19] = '{1,1,0,0,0,0,  1,2,2,0,0,0,2};  // down 2->1
        tbl[20] = '{1,0,0,0,0,0,  0,0,1,1,0,0,1};
        tbl[21] = '{1,1,1,0,0,0,  2,1,1,0,0,0,1};  // 1->2 ...
        tbl[22] = '{1,1,1,0,1,0,  0,0,2,1,1,0,0};  // ... bank forced to 0
        tbl[23] = '{1,1,1,0,0,0,  0,0,2,0,1,0,0};  // FAULT ignores en
        tbl[24] = '{1,1,1,1,0,0,  0,0,0,0,0,0,0};  // clr_err beats en
        tbl[25] = '{1,0,0,0,0,0,  0,0,0,0,0,0,0};
        tbl[26] = '{1,1,1,0,0,0,  1,0,0,0,0,0,0};
        tbl[27] = '{0,1,1,0,0,0,  0,0,0,0,0,1,0};  // reset mid-DRIVE
        tbl[28] = '{1,1,1,0,0,0,  0,0,0,0,0,0,0};
        tbl[29] = '{1,1,1,0,0,0,  1,0,0,0,0,0,0};
        tbl[30] = '{1,0,0,0,0,0,  0,0,1,1,0,0,1};

        for (int i = 0; i < 31; i++) begin
            cyc_a(tbl[i].r[0], tbl[i].e[0], tbl[i].u[0], tbl[i].c[0], tbl[i].f[0], tbl[i].fv);
            chk($sformatf("vec%0d j", i),         int'(j_a),    tbl[i].xj);
            chk($sformatf("vec%0d k", i),         int'(k_a),    tbl[i].xk);
            chk($sformatf("vec%0d expected", i),  int'(exp_a),  tbl[i].xe);
            chk($sformatf("vec%0d step_done", i), int'(done_a), tbl[i].xd);
            chk($sformatf("vec%0d mismatch", i),  int'(mis_a),  tbl[i].xm);
            chk($sformatf("vec%0d ff_rst", i),    int'(ff_a),   tbl[i].xff);
            chk($sformatf("vec%0d bank_q", i),    int'(bank_a), tbl[i].xq);
        end

        // MAX_COUNT=2 build: bank forced to an illegal 3, then resync.
        cyc_b(0, 0, 0, 0, 0, 0);
        chk("b_reset ff_rst", int'(ff_b), 1);
        cyc_b(1, 1, 1, 0, 0, 0);
        chk("b_release j", int'(j_b), 0);
        cyc_b(1, 1, 1, 0, 0, 0);
        chk("b_step j", int'(j_b), 1);
        cyc_b(1, 0, 0, 0, 1, 3);
        chk("b_force step_done", int'(done_b), 1);
        chk("b_force mismatch", int'(mis_b), 1);
        chk("b_force expected", int'(exp_b), 1);
        cyc_b(1, 1, 1, 0, 0, 0);
        chk("b_fault j", int'(j_b), 0);
        chk("b_fault bank", int'(bank_b), 3);
        cyc_b(1, 1, 1, 1, 0, 0);
        chk("b_clr ff_rst", int'(ff_b), 1);
        chk("b_clr expected", int'(exp_b), 0);
        chk("b_clr mismatch", int'(mis_b), 0);
        chk("b_clr bank", int'(bank_b), 0);
        cyc_b(1, 1, 1, 0, 0, 0);
        chk("b_post ff_rst", int'(ff_b), 0);
        chk("b_post j", int'(j_b), 0);
        cyc_b(1, 1, 1, 0, 0, 0);
        chk("b_resume j", int'(j_b), 1);

        // Randomized run of DUT A against the model.
        for (int c = 0; c < 2000; c++) begin
            bit r, e, u, cl, f;
            int fv;
            r  = !(c == 0 || $urandom_range(0, 39) == 0);
            e  = ($urandom_range(0, 9) < 6);
            u  = 1'($urandom_range(0, 1));
            cl = ($urandom_range(0, 3) == 0);
            f  = ($urandom_range(0, 11) == 0);
            fv = int'($urandom_range(0, 3));
            cyc_a(r, e, u, cl, f, fv);
            model_step(r, e, u, cl, q_cap);
            chk($sformatf("rnd%0d j", c),         int'(j_a),    m_j);
            chk($sformatf("rnd%0d k", c),         int'(k_a),    m_k);
            chk($sformatf("rnd%0d expected", c),  int'(exp_a),  m_exp);
            chk($sformatf("rnd%0d step_done", c), int'(done_a), int'(m_done));
            chk($sformatf("rnd%0d mismatch", c),  int'(mis_a),  int'(m_err));
            chk($sformatf("rnd%0d ff_rst", c),    int'(ff_a),   int'(m_ff));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/jk_excitation_driver.md
# jk_excitation_driver

Synchronous controller that steps an external bank of negedge-clocked JK flip-flop cells through a mod-(MAX_COUNT+1) up/down count. It generates J/K excitation for the bank from the desired next state using the inverted JK characteristic table. On the following edge it reads back the bank's Q outputs and flags any divergence. It sits between the counter control logic and the JK flip-flop bank in the count-to-three datapath.

## Interface
- WIDTH, 2, number of JK cells driven / count width
- MAX_COUNT, 3, terminal count; must satisfy MAX_COUNT < 2**WIDTH
- clk  input  1  system clock; this block uses the rising edge, the JK bank uses the falling edge
- rst  input  1  reset, synchronous and active-low
- en  input  1  request one count step
- up  input  1  direction: 1 = increment, 0 = decrement; sampled with en
- clr_err  input  1  leave FAULT and resynchronise to the bank
- q_fb  input  WIDTH  Q outputs of the JK bank
- j  output  WIDTH  J inputs to the JK bank
- k  output  WIDTH  K inputs to the JK bank
- ff_rst  output  1  active-high reset to the JK bank
- expected  output  WIDTH  count the bank is required to hold
- step_done  output  1  one-cycle pulse when a step completes its check
- mismatch  output  1  sticky error; q_fb differed from the target

## Operation
- States: IDLE, DRIVE, FAULT. All outputs are registered.
- Reset (rst=0 at a rising edge) sets:
  - state = IDLE
  - j = 0, k = 0
  - expected = 0
  - step_done = 0
  - mismatch = 0
  - ff_rst = 1
- ff_rst deasserts on the first rising edge with rst=1.
- IDLE:
  - j = k = 0, so the bank holds.
  - en is ignored while ff_rst = 1.
  - If en = 1, compute target = expected ± 1 with wrap: up MAX_COUNT→0, down 0→MAX_COUNT.
  - Per bit, from present q_fb[i] to target[i], drive {j,k}: 0→0: 00; 0→1: 10; 1→0: 01; 1→1: 00. Don't-cares resolve to 0.
  - Latch target, then go to DRIVE.
- DRIVE:
  - j/k are held for the whole cycle; the bank updates on the mid-cycle falling edge.
  - At the next rising edge:
    - sample q_fb
    - expected ← target
    - j = k = 0
    - step_done = 1 for one cycle
  - If q_fb == target, go to IDLE. Otherwise set mismatch = 1 and go to FAULT.
  - en and up are ignored while in DRIVE.
- FAULT:
  - j = k = 0 and en is ignored.
  - On clr_err = 1: expected ← q_fb, mismatch ← 0, go to IDLE.
  - If q_fb > MAX_COUNT, expected ← 0 and ff_rst pulses for one cycle.
- Simultaneous en and clr_err in FAULT: clr_err wins and en is dropped.
- Reset during DRIVE: the step is abandoned and the reset values apply on that edge.

## Timing
- Step latency: en sampled at edge N; j/k valid N→N+1; bank updates at the falling edge in between; check and step_done at N+1.
- Maximum step rate: one step per 2 cycles. If en is held high, the next step starts at the N+2 edge.
- expected changes at the same edge as step_done, even on mismatch.
- After rst rises: ff_rst=1 for one more cycle, so the first accepted en is at the second edge after reset release.
- The bank's q_fb must settle within half a clock period.

## Structure
- Package jk_drv_pkg holds:
  - the typedef enum for the states (IDLE, DRIVE, FAULT)
  - a function jk_excite(q, q_next) returning {J,K} per the table above
  - a function next_count(cnt, up, max) with the wrap rule
- No sub-module inside the RTL; the excitation is a per-bit generate loop calling jk_excite.
- The test bench instantiates WIDTH of the team's negedge JK flip-flop cells as the load. Their reset is driven from ff_rst and their clock from clk.

## Test plan
- Reset, then en=1, up=1 held high with WIDTH=2, MAX=3 → expected and q_fb go 1,2,3,0,1, with step_done every 2nd cycle and mismatch=0.
- Count down from 0 → first step: j=2'b11, k=2'b00, expected=3; next step: j=2'b00, k=2'b01, expected=2.
- Force the bank to 2'b00 at the falling edge during the 1→2 step → at the check edge: step_done=1, mismatch=1, state FAULT, expected=2; with clr_err=1 → expected=0, mismatch=0, IDLE.
- Pulse en while the block is in DRIVE and FAULT → no extra step and j=k=0 in FAULT; en together with clr_err → only the resync occurs.
- Assert rst=0 in the middle of DRIVE → at that edge j=k=0, expected=0, ff_rst=1, bank Q=0. After release, en is ignored for 1 cycle.
- Force q_fb=3 on a build with MAX_COUNT=2, then clr_err → ff_rst pulses, expected=0.
